// File: rtl/muldiv_pkg.sv
// Purpose: shared constants for the RV32M issue sequencer: funct3 codes, FSM states, special results.
// Latency: n/a (package only).
// Backpressure: n/a.
package muldiv_pkg;

    // RV32M funct3 encodings. Bit 2 separates the divide family from the multiply family.
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FIX    = 3'd3,
        ST_DONE   = 3'd4,
        ST_DRAIN  = 3'd5
    } state_t;

    // Architectural results for divide-by-zero and signed overflow.
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

endpackage

// File: rtl/muldiv_signfix.sv
// Purpose: operand magnitude/sign generation and signed result recovery around an unsigned mul/div core.
// Latency: purely combinational.
// Backpressure: none; the caller chooses which operand set to present.
//
// Ports: op/a/b - the operation and raw rs1/rs2; raw - 64-bit core result ({hi,lo} or {rem,quot});
//        abs_a/abs_b - unsigned operands for the core; mode - 0 multiply, 1 divide;
//        result - sign-corrected, half-selected rd value.
module muldiv_signfix
    import muldiv_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [63:0] raw,
    output logic [31:0] abs_a,
    output logic [31:0] abs_b,
    output logic        mode,
    output logic [31:0] result
);

    logic        sa;
    logic        sb;
    logic [63:0] v;

    always_comb begin
        sa = 1'b0;
        sb = 1'b0;
        // MUL shares operands with MULH so a MULH;MUL pair can hit the reuse store;
        // the low product bits are identical either way.
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                sa = a[31];
                sb = b[31];
            end
            OP_MULHSU: sa = a[31];
            default:   ;
        endcase

        abs_a = sa ? (~a + 32'd1) : a;
        abs_b = sb ? (~b + 32'd1) : b;
        mode  = op[2];

        v = raw;
        if (!mode) begin
            if (sa ^ sb) begin
                v = ~raw + 64'd1;
            end
        end else begin
            // Quotient carries the XOR of signs, remainder follows the dividend.
            v[31:0]  = (sa ^ sb) ? (~raw[31:0] + 32'd1) : raw[31:0];
            v[63:32] = sa ? (~raw[63:32] + 32'd1) : raw[63:32];
        end

        case (op)
            OP_MUL, OP_DIV, OP_DIVU: result = v[31:0];
            default:                 result = v[63:32];
        endcase
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Purpose: issues one RV32M op at a time to the iterative unsigned mul/div core, fixes signs, handles div special cases.
// Latency: core path accept->resp_valid 36 cycles; div-by-zero/overflow 1 cycle; reuse hit (MULDIV_REUSE_EN) 2 cycles.
// Backpressure: one op in flight; req_ready only in IDLE, result held in DONE until resp_ready; stall holds EX.
//
// Ports: req_* - EX-stage request (funct3 op, rs1, rs2); flush - drop the in-flight op;
//        resp_* - result handshake; stall - pipeline hold; core_* - launch pulse, operands and
//        completion pulse/result of the 32-step core (core shares rst_n).
// Build option: define MULDIV_REUSE_EN to keep the last core operands/result and skip the core on a repeat.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int CORE_STEPS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [2:0]        req_op,
    input  logic [XLEN-1:0]   req_a,
    input  logic [XLEN-1:0]   req_b,
    output logic              req_ready,
    input  logic              flush,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_data,
    input  logic              resp_ready,
    output logic              stall,
    output logic              core_valid,
    output logic              core_mode,
    output logic [XLEN-1:0]   core_a,
    output logic [XLEN-1:0]   core_b,
    input  logic              core_ready,
    input  logic [2*XLEN-1:0] core_out
);

    // Only the 32-bit, 32-step core exists; other settings fall into this empty branch
    // and are not supported.
    if (XLEN != 32 || CORE_STEPS != 32) begin : g_unsupported_cfg
    end

    state_t      state;
    state_t      state_nxt;

    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] core_out_q;
    logic [31:0] res_q;

    logic        in_idle;
    logic        accept;
    logic        special;
    logic [31:0] special_res;
    logic        reuse_hit;

    logic [2:0]  sf_op;
    logic [31:0] sf_a;
    logic [31:0] sf_b;
    logic [31:0] sf_abs_a;
    logic [31:0] sf_abs_b;
    logic        sf_mode;
    logic [31:0] sf_result;

    assign in_idle = (state == ST_IDLE);
    // Flush outranks a new request in IDLE.
    assign accept  = in_idle & req_valid & ~flush;

    // One sign-fix instance: the live request in IDLE, the captured op afterwards (used in FIX).
    assign sf_op = in_idle ? req_op : op_q;
    assign sf_a  = in_idle ? req_a  : a_q;
    assign sf_b  = in_idle ? req_b  : b_q;

    muldiv_signfix u_signfix (
        .op     (sf_op),
        .a      (sf_a),
        .b      (sf_b),
        .raw    (core_out_q),
        .abs_a  (sf_abs_a),
        .abs_b  (sf_abs_b),
        .mode   (sf_mode),
        .result (sf_result)
    );

    // Divide family only; op[0]==0 marks the signed DIV/REM where INT_MIN/-1 overflows.
    assign special = req_op[2] &
                     ((req_b == '0) | (~req_op[0] & (req_a == INT_MIN) & (req_b == ALL_ONES)));

    // op[1] separates REM/REMU from DIV/DIVU.
    always_comb begin
        special_res = ALL_ONES;
        if (req_b == '0) begin
            special_res = req_op[1] ? req_a : ALL_ONES;
        end else begin
            special_res = req_op[1] ? 32'd0 : INT_MIN;
        end
    end

`ifdef MULDIV_REUSE_EN
    logic [31:0] last_a;
    logic [31:0] last_b;
    logic        last_mode;
    logic        reuse_vld;

    // core_out_q doubles as the stored raw result: it only changes on a real WAIT capture,
    // the same event that refreshes the operand tags.
    assign reuse_hit = reuse_vld & (sf_abs_a == last_a) & (sf_abs_b == last_b) & (sf_mode == last_mode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_a    <= '0;
            last_b    <= '0;
            last_mode <= 1'b0;
            reuse_vld <= 1'b0;
        end else if (flush && (state == ST_LAUNCH || state == ST_WAIT || state == ST_DRAIN)) begin
            reuse_vld <= 1'b0;
        end else if (state == ST_WAIT && core_ready) begin
            last_a    <= core_a;
            last_b    <= core_b;
            last_mode <= core_mode;
            reuse_vld <= 1'b1;
        end
    end
`else
    assign reuse_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (special) begin
                        state_nxt = ST_DONE;
                    end else if (reuse_hit) begin
                        state_nxt = ST_FIX;
                    end else begin
                        state_nxt = ST_LAUNCH;
                    end
                end
            end
            // The core cannot abort once launched, so a flush must wait out its completion.
            ST_LAUNCH: state_nxt = flush ? ST_DRAIN : ST_WAIT;
            ST_WAIT: begin
                if (flush) begin
                    // Completion arriving with the flush leaves nothing to drain.
                    state_nxt = core_ready ? ST_IDLE : ST_DRAIN;
                end else if (core_ready) begin
                    state_nxt = ST_FIX;
                end
            end
            ST_FIX:   state_nxt = flush ? ST_IDLE : ST_DONE;
            ST_DONE: begin
                if (flush || resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (core_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        req_ready  = 1'b0;
        core_valid = 1'b0;
        resp_valid = 1'b0;
        case (state)
            ST_IDLE:   req_ready  = 1'b1;
            ST_LAUNCH: core_valid = 1'b1;
            ST_DONE:   resp_valid = 1'b1;
            default:   ;
        endcase
    end

    assign stall     = (req_valid & ~resp_valid) | (~in_idle & ~resp_valid);
    assign resp_data = res_q;

    // Datapath captures. core_a/core_b/core_mode stay put from accept until the next accept,
    // which keeps them stable across LAUNCH, WAIT and DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            core_a     <= '0;
            core_b     <= '0;
            core_mode  <= 1'b0;
            core_out_q <= '0;
            res_q      <= '0;
        end else begin
            if (accept) begin
                op_q      <= req_op;
                a_q       <= req_a;
                b_q       <= req_b;
                core_a    <= sf_abs_a;
                core_b    <= sf_abs_b;
                core_mode <= sf_mode;
                if (special) begin
                    res_q <= special_res;
                end
            end
            // core_ready in any other state is stray and must not disturb the stored result.
            if (state == ST_WAIT && core_ready && !flush) begin
                core_out_q <= core_out;
            end
            if (state == ST_FIX) begin
                res_q <= sf_result;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    localparam logic [31:0] K_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] K_MIN  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_ready = 1'b0;
    logic        stall;
    logic        core_valid;
    logic        core_mode;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_ready = 1'b0;
    logic [63:0] core_out = '0;

    muldiv_sequencer #(.XLEN(32), .CORE_STEPS(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .stall      (stall),
        .core_valid (core_valid),
        .core_mode  (core_mode),
        .core_a     (core_a),
        .core_b     (core_b),
        .core_ready (core_ready),
        .core_out   (core_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (architectural rules) ----------------
    function automatic bit sgn_a(input logic [2:0] op);
        return (op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6);
    endfunction

    function automatic bit sgn_b(input logic [2:0] op);
        return (op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd6);
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] x, input bit s);
        return (s && x[31]) ? 32'(-x) : x;
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return (op >= 3'd4) && (b == 0 || ((op == 3'd4 || op == 3'd6) && a == K_MIN && b == K_ONES));
    endfunction

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        p  = '0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return K_ONES;
                if (a == K_MIN && b == K_ONES) return K_MIN;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? K_ONES : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == K_MIN && b == K_ONES) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

`ifdef MULDIV_REUSE_EN
    bit          m_vld = 1'b0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    bit          m_mode = 1'b0;
`endif

    function automatic bit reuse_expect(input logic [31:0] ea, input logic [31:0] eb, input bit em);
`ifdef MULDIV_REUSE_EN
        return m_vld && ea == m_a && eb == m_b && em == m_mode;
`else
        return (ea != ea) && em;
`endif
    endfunction

    task automatic reuse_note(input logic [31:0] ea, input logic [31:0] eb, input bit em);
`ifdef MULDIV_REUSE_EN
        m_vld = 1'b1; m_a = ea; m_b = eb; m_mode = em;
`else
        if (ea == eb && em) begin end
`endif
    endtask

    task automatic reuse_clear();
`ifdef MULDIV_REUSE_EN
        m_vld = 1'b0;
`endif
    endtask

    // ---------------- core model: core_ready 33 cycles after the launch cycle ----------------
    int          core_cnt = 0;
    bit          core_pend = 1'b0;
    logic [31:0] cm_a = '0;
    logic [31:0] cm_b = '0;
    logic        cm_mode = 1'b0;
    int          n_launch = 0;
    int          spur_cnt = 0;
    int          spur_seen = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_pend  = 1'b0;
            core_ready = 1'b0;
            core_out   = '0;
            spur_seen  = spur_cnt;
        end else begin
            core_ready = 1'b0;
            if (core_pend) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    core_pend  = 1'b0;
                    core_ready = 1'b1;
                    if (cm_mode) core_out = (cm_b != 0) ? {cm_a % cm_b, cm_a / cm_b} : 64'd0;
                    else         core_out = {32'b0, cm_a} * {32'b0, cm_b};
                    chk("core_ab_held", {core_a, core_b}, {cm_a, cm_b});
                end
            end else if (spur_seen != spur_cnt) begin
                spur_seen  = spur_cnt;
                core_ready = 1'b1;
                core_out   = {$urandom, $urandom};
            end
            if (core_valid) begin
                core_pend = 1'b1;
                core_cnt  = 33;
                cm_a      = core_a;
                cm_b      = core_b;
                cm_mode   = core_mode;
                n_launch++;
            end
        end
    end

    // ---------------- stimulus helpers (all start and end at a negedge) ----------------
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp_d, ea, eb;
        bit          spec, hit, em;
        int          exp_lat, lat, wait_n, st_low, l0;
        spec    = is_special(op, a, b);
        ea      = mag(a, sgn_a(op));
        eb      = mag(b, sgn_b(op));
        em      = op[2];
        hit     = !spec && reuse_expect(ea, eb, em);
        exp_d   = ref_res(op, a, b);
        exp_lat = spec ? 1 : (hit ? 2 : 36);
        wait_n  = 0;
        while (!req_ready && wait_n < 100) begin @(negedge clk); wait_n++; end
        l0 = n_launch;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        #1 chk("stall_accept", 64'(stall), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; st_low = 0;
        while (!resp_valid && lat < 100) begin
            if (!stall) st_low++;
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("stall_busy", 64'(st_low), 64'd0);
        chk("core_launches", 64'(n_launch - l0), (spec || hit) ? 64'd0 : 64'd1);
        if (!spec && !hit) begin
            chk("core_operands", {cm_a, cm_b}, {ea, eb});
            chk("core_mode", 64'(cm_mode), 64'(em));
        end
        chk("resp_data", 64'(resp_data), 64'(exp_d));
        chk("stall_done", 64'(stall), 64'd0);
        for (int h = 0; h < hold; h++) begin
            if (h == 0 && hold >= 3) spur_cnt++;
            @(negedge clk);
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_data", 64'(resp_data), 64'(exp_d));
            chk("hold_req_ready", 64'(req_ready), 64'd0);
            chk("hold_stall", 64'(stall), 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_drop", 64'(resp_valid), 64'd0);
        if (!spec && !hit) reuse_note(ea, eb, em);
    endtask

    task automatic flush_test();
        int c, bad_rdy, bad_vld;
        req_valid = 1'b1; req_op = 3'd0; req_a = 32'h0000_1234; req_b = 32'h0000_0055;
        @(negedge clk);
        req_valid = 1'b0; c = 1;
        while (c < 10) begin @(negedge clk); c++; end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; c++;
        bad_rdy = 0; bad_vld = 0;
        while (c < 35) begin
            if (req_ready) bad_rdy++;
            if (resp_valid) bad_vld++;
            @(negedge clk);
            c++;
        end
        chk("drain_req_ready_low", 64'(bad_rdy), 64'd0);
        chk("drain_no_resp", 64'(bad_vld), 64'd0);
        chk("drain_req_ready_back", 64'(req_ready), 64'd1);
        reuse_clear();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_core_valid"}, 64'(core_valid), 64'd0);
        chk({tag, "_stall"}, 64'(stall), 64'd0);
        chk({tag, "_resp_data"}, 64'(resp_data), 64'd0);
        chk({tag, "_core_ab"}, {core_a, core_b}, 64'd0);
        chk({tag, "_core_mode"}, 64'(core_mode), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return K_MIN;
            2:       return K_ONES;
            3:       return ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 20)) : 32'(-$urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [2:0] partner(input logic [2:0] op);
        case (op)
            3'd0: return 3'd1;
            3'd1: return 3'd0;
            3'd4: return 3'd6;
            3'd6: return 3'd4;
            3'd5: return 3'd7;
            3'd7: return 3'd5;
            default: return op;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 0);
        chk("mul_core_a", 64'(cm_a), 64'd3);
        chk("mul_core_b", 64'(cm_b), 64'd7);
        run_op(3'd2, K_MIN, K_ONES, 2);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5);
        run_op(3'd5, 32'd5, 32'd0, 0);
        run_op(3'd4, K_MIN, K_ONES, 1);
        run_op(3'd7, 32'd9, 32'd0, 0);
        run_op(3'd5, K_MIN, K_ONES, 0);

        // Flush while the core runs, then an immediate follow-up request.
        flush_test();
        run_op(3'd0, 32'h0000_1234, 32'h0000_0055, 0);

        // Flush beats a request in IDLE.
        req_valid = 1'b1; req_op = 3'd5; req_a = 32'd3; req_b = 32'd0; flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_no_accept", 64'(req_ready), 64'd1);
        chk("idle_flush_no_resp", 64'(resp_valid), 64'd0);

        // Flush in DONE drops the response.
        req_valid = 1'b1; req_op = 3'd5; req_a = 32'd3; req_b = 32'd0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("done_flush_pre", 64'(resp_valid), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("done_flush_resp", 64'(resp_valid), 64'd0);
        chk("done_flush_ready", 64'(req_ready), 64'd1);

        // Reset while waiting on the core.
        req_valid = 1'b1; req_op = 3'd3; req_a = 32'hDEAD_BEEF; req_b = 32'h1234_5678;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("wait_busy", 64'(req_ready), 64'd0);
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        reuse_clear();

        // Randomized ops, often followed by the partner op on the same operands.
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op(op, a, b, $urandom_range(0, 4));
            if ($urandom_range(0, 1) != 0) run_op(partner(op), a, b, 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Issue/sequence controller that sits between the EX stage and the iterative 32-step unsigned multiply/divide core. It accepts one RV32M operation at a time and handles:
- signed-operand fix-up (absolute values into the core);
- launching the core;
- waiting for core completion;
- result sign correction and half selection;
- RISC-V divide-by-zero/overflow special cases, without using the core.

It holds the pipeline with a stall output and supports flush while the core is busy.

Parameters:
XLEN, 32, operand/result width (core is fixed at 32; other values unsupported)
CORE_STEPS, 32, core iteration count; documents latency only, no logic depends on it

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  EX stage presents an M-extension op
req_op  input  3  funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
req_a  input  32  rs1 value
req_b  input  32  rs2 value
req_ready  output  1  sequencer can accept (state IDLE)
flush  input  1  discard in-flight op
resp_valid  output  1  result available
resp_data  output  32  final rd value
resp_ready  input  1  consumer takes result
stall  output  1  = (req_valid & ~resp_valid) | (state != IDLE & ~resp_valid)
core_valid  output  1  one-cycle launch pulse to core
core_mode  output  1  0 multiply, 1 divide
core_a  output  32  unsigned dividend/multiplicand
core_b  output  32  unsigned divisor/multiplier
core_ready  input  1  core OUT-state pulse; core_out valid this cycle
core_out  input  64  multiply: {hi,lo}; divide: {remainder,quotient}

Behaviour:
- Reset (async, rst_n=0): state IDLE, all outputs 0 except req_ready=1; captured registers 0.
- States: IDLE, LAUNCH, WAIT, FIX, DONE, DRAIN.
- IDLE:
  - Accept on req_valid&req_ready; latch op, a, b.
  - Signed flags: MULH both operands; MULHSU a only; DIV/REM both.
  - core_a/core_b = abs of signed operands, raw otherwise; neg_res = sa^sb (MUL family, DIV); neg_res = sa (REM).
  - Special cases go straight to DONE next cycle, no core use:
    - b==0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → a.
    - a==0x80000000 & b==0xFFFFFFFF: DIV → 0x80000000; REM → 0.
  - All other ops go to LAUNCH.
- LAUNCH: core_valid=1 for exactly one cycle; core_a/b/mode held stable → WAIT.
- WAIT: core_a/b held. On core_ready, capture core_out → FIX.
- FIX:
  - Form 64-bit value v = neg_res ? -core_out : core_out. For divide, negate quotient and remainder halves independently: quotient with sa^sb, remainder with sa.
  - Select: MUL/DIV/DIVU lo; MULH/MULHSU/MULHU hi; REM/REMU hi.
  - → DONE.
- DONE: resp_valid=1, resp_data stable until resp_ready; then → IDLE. No new accept in the same cycle.
- Latency, accept cycle 0:
  - Core path: core_valid cycle 1, core_ready cycle 34, resp_valid cycle 36.
  - Special case: resp_valid cycle 1.
- Flush:
  - In LAUNCH/WAIT → DRAIN (core cannot abort). DRAIN waits for core_ready, discards the result → IDLE. req_ready=0 throughout.
  - In FIX/DONE → IDLE, resp_valid deasserts next cycle.
  - In IDLE, flush has priority over req_valid: no accept.
- Spurious core_ready outside WAIT/DRAIN is ignored.
- Reset mid-operation returns to IDLE at once. The core is reset by the same rst_n.

Optional Feature:
MULDIV_REUSE_EN:
- When defined: store the last core_a, core_b, core_mode and raw core_out, plus a valid bit.
- A new non-special request with an identical {core_a, core_b, core_mode} and a set valid bit skips LAUNCH/WAIT and goes IDLE→FIX. This makes MULH;MUL and DIV;REM pairs take resp_valid at cycle 2.
- The valid bit clears on reset and on any flush during LAUNCH/WAIT/DRAIN.
- When undefined: no storage; every non-special op uses the core.

Decomposition:
- Package muldiv_pkg: op funct3 constants, state encoding constants, special-case result constants (ALL_ONES, INT_MIN).
- One sub-module, muldiv_signfix (combinational): operand abs/sign flag generation and 64-bit result negation/half select. The FSM stays in muldiv_sequencer.

Test Plan:
- MUL a=0xFFFFFFFD (-3), b=7 → core_a=3, core_b=7; resp_data=0xFFFFFFEB at cycle 36; stall high cycles 0-35.
- MULHSU a=0x80000000, b=0xFFFFFFFF → resp_data=0x80000000.
- DIV a=-7, b=2 → quotient 0xFFFFFFFD; then REM same operands → 0xFFFFFFFF. With MULDIV_REUSE_EN, the second result arrives at cycle 2.
- DIVU a=5, b=0 → 0xFFFFFFFF at cycle 1, core_valid never asserted; DIV 0x80000000/0xFFFFFFFF → 0x80000000.
- flush at cycle 10 of a MUL → DRAIN, req_ready=0 until core_ready (cycle 34), no resp_valid; next request accepted cycle 35.
- resp_ready held low 5 cycles in DONE → resp_data stable, stall deasserted while resp_valid, req_ready stays 0; rst_n pulse in WAIT → all outputs at reset values immediately.
